// File: rtl/serial_adder_pkg.sv
// Shared state encoding for the bit-serial adder controller.
package serial_adder_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder made from two half adders; the carries can never both be set.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (.a(a),    .b(b),   .sum(w_s0), .carry(w_c0));
  half_adder u_ha1 (.a(w_s0), .b(cin), .sum(sum),  .carry(w_c1));

  assign cout = w_c0 | w_c1;
endmodule

// File: rtl/half_adder.sv
// One-bit half adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: accepts an operand pair in IDLE, adds one bit per cycle in SHIFT,
// presents sum/carry_out in DONE until the consumer takes it.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_fa_sum;
  logic             w_fa_cout;

  full_adder u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = SHIFT;
      SHIFT:   if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
      r_carry <= w_fa_cout;
      if (!w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == SHIFT);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign carry_out = r_carry;
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair a/b is valid.
REQ-005 SHALL have port in_ready  output  1  controller can accept an operand pair.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port sum  output  WIDTH  result a+b modulo 2^WIDTH.
REQ-009 SHALL have port carry_out  output  1  carry out of bit WIDTH-1.
REQ-010 SHALL have port out_valid  output  1  sum/carry_out are valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port busy  output  1  high while in SHIFT state.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; accept occurs on in_valid && in_ready at a rising edge.
REQ-015 On accept SHALL capture a and b into shift registers, clear carry register, clear bit counter, clear sum register, go to SHIFT.
REQ-016 In SHIFT SHALL feed LSB of each operand register plus carry register to one full-adder per cycle, shift result bit into sum register from MSB side, store adder carry, right-shift operands.
REQ-017 Bit counter SHALL be $clog2(WIDTH) bits wide; SHIFT lasts exactly WIDTH cycles, leaving at counter == WIDTH-1.
REQ-018 SHALL enter DONE on the edge that processes bit WIDTH-1; out_valid=1 in DONE only; latency from accept edge to out_valid high = WIDTH+1 edges.
REQ-019 In DONE SHALL hold sum, carry_out stable until out_valid && out_ready, then go to IDLE on that edge.
REQ-020 in_valid in SHIFT or DONE SHALL be ignored (no capture, no state change).
REQ-021 a and b changing after accept SHALL NOT affect the result.
REQ-022 sum and carry_out SHALL retain last result in IDLE (not cleared) until next accept.
REQ-023 Arithmetic SHALL wrap modulo 2^WIDTH; overflow reported only via carry_out.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, in_ready=1, out_valid=0, busy=0, sum=0, carry_out=0, counter=0, carry register=0.
REQ-025 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; no result is ever presented for it.
REQ-026 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-027 State encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL live in shared package serial_adder_pkg.
REQ-028 Per-bit add SHALL be one sub-module full_adder (a, b, cin -> sum, cout), built from two existing half_adder instances plus OR.
REQ-029 Outputs in_ready, out_valid, busy SHALL be decoded from state register only (no combinational input-to-output path).

Verification (WIDTH=8)
REQ-030 a=8'h00, b=8'h00 accepted, out_ready=1 -> out_valid high 9 edges after accept, sum=8'h00, carry_out=0.
REQ-031 a=8'hFF, b=8'h01 -> sum=8'h00, carry_out=1; a=8'hA5, b=8'h5A -> sum=8'hFF, carry_out=0.
REQ-032 out_ready held low 5 cycles in DONE -> out_valid, sum, carry_out stable all 5 cycles; IDLE one edge after out_ready=1.
REQ-033 in_valid pulsed with a=8'h11,b=8'h22 during SHIFT of 8'h03+8'h04 -> result sum=8'h07, second pair never captured, in_ready=0 throughout.
REQ-034 rst_n pulsed low at 3rd SHIFT cycle -> immediately IDLE, out_valid=0, sum=0; next accept 8'h80+8'h80 -> sum=8'h00, carry_out=1.
REQ-035 Random back-to-back operands (1000 pairs, random out_ready) SHALL match a+b reference model exactly.
